// File: rtl/msj_display_pkg.sv
// ---------------------------------------------------------------------------
// msj_display_pkg
// Shared types and constants for the msj_display block: converter FSM state
// encoding, the alarm message code, fixed segment patterns, and the
// add-3 step of the shift-add-3 binary-to-BCD conversion.
// ---------------------------------------------------------------------------
package msj_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] ALARM_CODE = 8'hFF;
    localparam logic [6:0] SEG_DASH   = 7'b1000000;
    localparam logic [6:0] SEG_BLANK  = 7'b0000000;

    // Adds 3 to every BCD nibble that is 5 or more, so the following left
    // shift carries correctly into the next decimal digit.
    function automatic logic [11:0] add3_nibbles(input logic [11:0] b);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/msj_display_bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD digit to seven-segment decoder. Codes above 9 decode
// to a blank digit.
// Ports:
//   bcd  in  4  BCD digit
//   seg  out 7  segments a..g, active-high, bit0 = a
// ---------------------------------------------------------------------------
module bcd_to_seg7
    import msj_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/msj_display.sv
// ---------------------------------------------------------------------------
// msj_display
// Display stage for the maintenance FSM's 8-bit msj message. Each new value
// is captured, converted to three BCD digits by a sequential shift-add-3
// converter, and scanned onto a common three-digit seven-segment display.
// Value 8'hFF is the alarm code and is shown as three dashes.
//
// Parameters:
//   SCAN_DIV      cycles each digit stays enabled (>= 2)
//   BLINK_FRAMES  full scan frames per blink phase toggle (>= 1)
// Ports:
//   clk     in  1  system clock, rising edge
//   rst     in  1  asynchronous reset, active-low
//   msj_in  in  8  message value
//   seg     out 7  segments a..g, active-high, bit0 = a (registered)
//   an      out 3  one-hot digit enable, bit0 = units (registered)
//   busy    out 1  conversion in progress
// Configuration:
//   MSJ_BLINK_EN  when defined, alarm dashes blink every BLINK_FRAMES frames
// ---------------------------------------------------------------------------
module msj_display
    import msj_display_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int BLINK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] msj_in,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       busy
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    if (SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_cfg
        $error("msj_display: SCAN_DIV must be >= 2 and BLINK_FRAMES >= 1");
    end

    // Converter state
    state_t      state_q, state_d;
    logic [7:0]  cur_val_q, cur_val_d;
    logic [19:0] sr_q, sr_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [11:0] bcd_q, bcd_d;
    logic        alarm_q, alarm_d;
    logic        alarm_rise;

    // Scan state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic             wrap;

    // Output registers
    logic [6:0] seg_q, seg_d;
    logic [2:0] an_q, an_d;
    logic [3:0] nibble;
    logic [6:0] dec_seg;
    logic       blink_on;

    always_comb begin
        state_d    = state_q;
        cur_val_d  = cur_val_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        bcd_d      = bcd_q;
        alarm_d    = alarm_q;
        alarm_rise = 1'b0;
        case (state_q)
            IDLE: begin
                // Sampled only here, so edits made while busy collapse to
                // whatever value is present when the converter comes back.
                if (msj_in != cur_val_q) begin
                    cur_val_d = msj_in;
                    sr_d      = {12'b0, msj_in};
                    bit_cnt_d = 4'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                sr_d      = {add3_nibbles(sr_q[19:8]), sr_q[7:0]} << 1;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d      = sr_q[19:8];
                alarm_d    = (cur_val_q == ALARM_CODE);
                alarm_rise = alarm_d && !alarm_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wrap = (cnt_q == CNT_W'(SCAN_DIV - 1));

    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        dig_d = dig_q;
        if (wrap) begin
            dig_d = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
        end
    end

`ifdef MSJ_BLINK_EN
    localparam int BL_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_on_q, blink_on_d;
    logic            frame_end;

    assign frame_end = wrap && (dig_q == 2'd2);

    // Phase restarts "on" at every alarm entry and is parked there while
    // no alarm is shown.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (alarm_rise || !alarm_q) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (frame_end) begin
            if (blink_cnt_q == BL_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = !blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign blink_on = blink_on_q;
`else
    assign blink_on = 1'b1;
`endif

    always_comb begin
        case (dig_q)
            2'd0:    nibble = bcd_q[3:0];
            2'd1:    nibble = bcd_q[7:4];
            default: nibble = bcd_q[11:8];
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd (nibble),
        .seg (dec_seg)
    );

    always_comb begin
        an_d = 3'b001 << dig_q;
        if (alarm_q) begin
            seg_d = blink_on ? SEG_DASH : SEG_BLANK;
        end else begin
            seg_d = dec_seg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cur_val_q <= 8'd0;
            sr_q      <= 20'd0;
            bit_cnt_q <= 4'd0;
            bcd_q     <= 12'd0;
            alarm_q   <= 1'b0;
            cnt_q     <= '0;
            dig_q     <= 2'd0;
            seg_q     <= 7'b0111111;
            an_q      <= 3'b001;
        end else begin
            state_q   <= state_d;
            cur_val_q <= cur_val_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            bcd_q     <= bcd_d;
            alarm_q   <= alarm_d;
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_msj_display.sv
// ---------------------------------------------------------------------------
// tb_msj_display
// Self-checking bench for msj_display: a cycle-level behavioural model
// (decimal arithmetic, countdown for the conversion, time-based scan index)
// is compared with the DUT on every falling edge, plus directed literal
// checks and randomized message traffic.
// ---------------------------------------------------------------------------
module tb_msj_display;

    localparam int SCAN_DIV     = 16;
    localparam int BLINK_FRAMES = 8;
    localparam int FRAME        = 3 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] msj_in;
    logic [6:0] seg;
    logic [2:0] an;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    msj_display #(
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .msj_in (msj_in),
        .seg    (seg),
        .an     (an),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [6:0] seg_tab [10];
    initial begin
        seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B;
        seg_tab[3] = 7'h4F; seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D;
        seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07; seg_tab[8] = 7'h7F;
        seg_tab[9] = 7'h6F;
    end

    function automatic logic [6:0] digit_seg(input int val, input int d);
        int dv;
        if (d == 0)      dv = val % 10;
        else if (d == 1) dv = (val / 10) % 10;
        else             dv = val / 100;
        return seg_tab[dv];
    endfunction

    int         m_cur, m_cnt, m_disp, m_t, m_fc;
    bit         m_alarm;
    logic [6:0] exp_seg;
    logic [2:0] exp_an;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cur = 0; m_cnt = 0; m_disp = 0; m_alarm = 1'b0;
            m_t = 0; m_fc = 0;
            exp_seg = 7'h3F; exp_an = 3'b001;
        end else begin
            int d;
            bit on;
            d  = (m_t / SCAN_DIV) % 3;
`ifdef MSJ_BLINK_EN
            on = ((m_fc / BLINK_FRAMES) % 2) == 0;
`else
            on = 1'b1;
`endif
            exp_an  = 3'b001 << d;
            exp_seg = m_alarm ? (on ? 7'h40 : 7'h00) : digit_seg(m_disp, d);
            if (!m_alarm) m_fc = 0;
            else if (m_t % FRAME == FRAME - 1) m_fc++;
            if (m_cnt == 0) begin
                if (int'(msj_in) != m_cur) begin
                    m_cur = int'(msj_in);
                    m_cnt = 9;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    if (!m_alarm && m_cur == 255) m_fc = 0;
                    m_alarm = (m_cur == 255);
                    m_disp  = m_cur;
                end
            end
            m_t++;
        end
    end

    // ---------------- continuous compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            vectors++;
            if (seg !== exp_seg || an !== exp_an || busy !== (m_cnt != 0)) begin
                miscompares++;
                $display("FAIL model t=%0d: seg=%h an=%b busy=%b required seg=%h an=%b busy=%b",
                         m_t, seg, an, busy, exp_seg, exp_an, (m_cnt != 0));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pin(input string nm, input logic [6:0] s_act, input logic [6:0] s_exp,
                       input logic [2:0] a_act, input logic [2:0] a_exp,
                       input logic b_act, input logic b_exp);
        vectors++;
        if (s_act !== s_exp || a_act !== a_exp || b_act !== b_exp) begin
            miscompares++;
            $display("FAIL %s: seg=%h an=%b busy=%b required seg=%h an=%b busy=%b",
                     nm, s_act, a_act, b_act, s_exp, a_exp, b_exp);
        end
    endtask

    task automatic check_digit(input int idx, input logic [6:0] expv, input string nm);
        int n;
        logic [2:0] want;
        n = 0;
        want = 3'b001 << idx;
        while (an !== want && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        vectors++;
        if (n >= 200 || seg !== expv) begin
            miscompares++;
            $display("FAIL %s: seg=%h an=%b required seg=%h an=%b", nm, seg, an, expv, want);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst    = 1'b0;
        msj_in = 8'd0;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        #1;
        pin("reset_outputs", seg, 7'h3F, an, 3'b001, busy, 1'b0);
        rst = 1'b1;

        // Idle with 0: no conversion, scan rotates showing "000".
        cycles(3 * FRAME);
        check_digit(1, 7'h3F, "zero_tens");
        check_digit(2, 7'h3F, "zero_hundreds");

        // 137: busy for 9 cycles after the capture edge.
        msj_in = 8'd137;
        @(posedge clk); #1;
        pin("busy_after_capture", seg, seg, an, an, busy, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        pin("busy_last_shift", seg, seg, an, an, busy, 1'b1);
        @(posedge clk); #1;
        pin("busy_after_done", seg, seg, an, an, busy, 1'b0);
        cycles(5);
        check_digit(0, 7'h07, "d137_units");
        check_digit(1, 7'h4F, "d137_tens");
        check_digit(2, 7'h06, "d137_hundreds");

        // Alarm: dashes on every digit.
        msj_in = 8'hFF;
        cycles(12);
        check_digit(0, 7'h40, "alarm_units");
        check_digit(1, 7'h40, "alarm_tens");
        check_digit(2, 7'h40, "alarm_hundreds");
`ifdef MSJ_BLINK_EN
        cycles(BLINK_FRAMES * FRAME);
        check_digit(0, 7'h00, "alarm_blink_off");
        cycles(BLINK_FRAMES * FRAME);
`else
        cycles(2 * BLINK_FRAMES * FRAME);
        check_digit(1, 7'h40, "alarm_steady");
`endif

        // Alarm clears to a steady "005".
        msj_in = 8'd5;
        cycles(14);
        check_digit(0, 7'h6D, "d5_units");
        check_digit(1, 7'h3F, "d5_tens");
        check_digit(2, 7'h3F, "d5_hundreds");
        cycles(2 * FRAME);

        // 42 then 99 three cycles later: both converted, "099" at the end.
        msj_in = 8'd42;
        cycles(3);
        msj_in = 8'd99;
        cycles(25);
        check_digit(0, 7'h6F, "d99_units");
        check_digit(1, 7'h6F, "d99_tens");
        check_digit(2, 7'h3F, "d99_hundreds");

        // Reset during the fifth shift of a 200 conversion.
        msj_in = 8'd200;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        pin("reset_mid_shift", seg, 7'h3F, an, 3'b001, busy, 1'b0);
        cycles(2);
        rst = 1'b1;
        cycles(20);
        check_digit(0, 7'h3F, "d200_units");
        check_digit(1, 7'h3F, "d200_tens");
        check_digit(2, 7'h5B, "d200_hundreds");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 60; i++) begin
            msj_in = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            cycles($urandom_range(1, 40));
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b0;
                cycles($urandom_range(1, 3));
                rst = 1'b1;
            end
        end
        cycles(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/msj_display.md
# msj_display

Downstream display stage for the maintenance FSM's 8-bit `msj` message. Captures each new message value, converts it to three BCD digits with a sequential shift-add-3 converter, and time-multiplexes the digits onto a common seven-segment display. Message value 8'hFF is the alarm code; it is shown as dashes instead of "255".

## Interface
Parameters:
- `SCAN_DIV`, 16: clock cycles each digit stays enabled (≥2).
- `BLINK_FRAMES`, 8: full 3-digit scan frames per blink phase toggle (≥1).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `msj_in`  in  8  message from the maintenance FSM.
- `seg`  out  7  segments a..g, active-high, bit0 = a.
- `an`  out  3  digit enable, one-hot, active-high; bit0 = units, bit2 = hundreds.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- Converter FSM states: `IDLE`, `SHIFT`, `DONE`.
- `IDLE`: if `msj_in != cur_val`, then `cur_val <= msj_in`, shift register `sr[19:0] <= {12'b0, msj_in}`, `bit_cnt <= 0`, go to `SHIFT`. Otherwise stay.
- `SHIFT`: each BCD nibble in `sr[19:8]` that is ≥5 gets +3, then the register shifts left by 1 and `bit_cnt` increments. After the 8th shift, go to `DONE`.
- `DONE`: `bcd_q <= sr[19:8]`, `alarm_q <= (cur_val == 8'hFF)`, go to `IDLE`.
- `busy` = state ≠ `IDLE`. Changes on `msj_in` while busy are ignored. On return to `IDLE`, the current `msj_in` is compared against `cur_val`, so only the newest value is converted.
- Scan: a divider counts 0..`SCAN_DIV`-1. On wrap, digit index advances 0→1→2→0.
- `an` is one-hot on the index. `seg` is the seven-segment decode of the selected `bcd_q` nibble.
- Leading digits are not blanked: 7 is shown as "007".
- Alarm (`alarm_q`=1): every digit shows a dash, `seg` = 7'b1000000, regardless of `bcd_q`.
- Width rules: the maximum value is 255, so the hundreds nibble is ≤2 and no overflow is possible. Nibble codes >9 cannot occur; if one did, the decode would be blank (7'b0).

## Timing
- Reset values: state `IDLE`, `cur_val`=0, `bcd_q`=0, `alarm_q`=0, scan counter 0, digit index 0, blink phase on.
- Reset output values: `an`=3'b001, `seg`=7'b0111111 ("0"), `busy`=0.
- No conversion runs for 0 after reset: `cur_val` already matches.
- Latency: `msj_in` first seen different at edge k (IDLE capture). Shifts occur on edges k+1..k+8. `bcd_q`/`alarm_q` update on edge k+9, and `busy` is high for cycles k+1..k+9.
- `seg`/`an` are registered. They reflect `bcd_q` and the digit index one cycle after those registers change.
- Digit period is `SCAN_DIV` cycles; frame period is 3·`SCAN_DIV`.
- `rst` low at any time, including mid-`SHIFT`, aborts the conversion and restores all reset values immediately. `bcd_q` keeps no partial result.
- Back-to-back value changes: minimum spacing between completed updates is 10 cycles.

## Configuration
- `MSJ_BLINK_EN` defined: while `alarm_q`=1, blink phase toggles every `BLINK_FRAMES` frames.
  - In the off phase `seg`=7'b0; `an` keeps scanning.
  - The blink counter and phase reset to on whenever `alarm_q` rises.
- `MSJ_BLINK_EN` not defined: no blink counter is built. Alarm dashes are steady.

## Structure
- Package `msj_display_pkg` holds:
  - `state_t` enum (`IDLE`, `SHIFT`, `DONE`).
  - `ALARM_CODE` = 8'hFF.
  - `SEG_DASH` = 7'b1000000.
  - `SEG_BLANK` = 7'b0000000.
- Sub-module `bcd_to_seg7`: 4-bit BCD in, 7-bit segments out, combinational. Instantiated once, on the scan mux output.

## Test plan
- Reset, then hold `msj_in`=0 → `busy` never rises; `an` cycles 001/010/100 every 16 cycles; `seg`=7'h3F on every digit.
- `msj_in` 0→8'd137 at edge k → `busy` high cycles k+1..k+9. Then units/tens/hundreds show 7'h07 ("7"), 7'h4F ("3"), 7'h06 ("1").
- `msj_in`=8'hFF → after 10 cycles all digits show 7'h40. With `MSJ_BLINK_EN`: `seg`=0 for 8 frames, dashes for 8 frames, repeating.
- `msj_in`=42 followed 3 cycles later by 99 → 42 is displayed first, then a second conversion starts on returning to `IDLE` and ends showing "099". No value is lost or corrupted.
- Assert `rst` low during the 5th shift of a 200 conversion → all outputs at reset values immediately. After release with `msj_in`=200, a full conversion reruns and shows "200".
- `msj_in`=8'hFF, then 8'd5 → alarm clears on the `DONE` edge; steady "005" with no blanking.
